// File: rtl/y_alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes, result flags, sticky overflow and op counter.
// Optional barrel shifter (SLL/SRL/SRA) is built only when ALU_SHIFT_EN is defined.
module y_alu_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic             ovf_sticky,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] op_count
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLT   = 4'b0011;
  localparam logic [3:0] OP_AND_L = 4'b0100;
  localparam logic [3:0] OP_OR_L  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT_L = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1001;
  localparam logic [3:0] OP_SLTU  = 4'b1011;
`ifdef ALU_SHIFT_EN
  localparam logic [3:0] OP_SLL   = 4'b1100;
  localparam logic [3:0] OP_SRL   = 4'b1101;
  localparam logic [3:0] OP_SRA   = 4'b1110;
  localparam int         SHW      = $clog2(WIDTH);
`endif

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [3:0]       r_s1_op;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_z;
  logic             r_zero;
  logic             r_ovf;
  logic             r_illegal;
  logic             r_ovf_sticky;
  logic [CNT_W-1:0] r_op_count;

  logic             w_adv;
  logic             w_out_fire;
  logic             w_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_addsub;
  logic             w_lt_u;
  logic             w_lt_s;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_illegal;
`ifdef ALU_SHIFT_EN
  logic [SHW-1:0]   w_shamt;
`endif

  // Global stall: both stages move together whenever the output slot is free or draining.
  assign w_adv      = !r_out_valid || out_ready;
  assign in_ready   = w_adv && rst_n;
  assign w_out_fire = r_out_valid && out_ready;

  // One adder serves ADD and SUB; SUB adds the inverted operand plus one.
  assign w_sub    = (r_s1_op == OP_SUB);
  assign w_b_eff  = w_sub ? ~r_s1_b : r_s1_b;
  assign w_addsub = r_s1_a + w_b_eff + WIDTH'(w_sub);

  // Signed compare from sign bits: differing signs decide directly, equal signs reduce to unsigned.
  assign w_lt_u = (r_s1_a < r_s1_b);
  assign w_lt_s = (r_s1_a[MSB] != r_s1_b[MSB]) ? r_s1_a[MSB] : w_lt_u;

`ifdef ALU_SHIFT_EN
  assign w_shamt = r_s1_b[SHW-1:0];
`endif

  always_comb begin
    w_res     = '0;
    w_ovf     = 1'b0;
    w_illegal = 1'b0;
    case (r_s1_op)
      OP_AND, OP_AND_L: w_res = r_s1_a & r_s1_b;
      OP_OR,  OP_OR_L:  w_res = r_s1_a | r_s1_b;
      OP_ADD, OP_SUB: begin
        w_res = w_addsub;
        w_ovf = (r_s1_a[MSB] == w_b_eff[MSB]) && (w_addsub[MSB] != r_s1_a[MSB]);
      end
      OP_SLT, OP_SLT_L: w_res = {{(WIDTH-1){1'b0}}, w_lt_s};
      OP_XOR:           w_res = r_s1_a ^ r_s1_b;
      OP_NOR:           w_res = ~(r_s1_a | r_s1_b);
      OP_SLTU:          w_res = {{(WIDTH-1){1'b0}}, w_lt_u};
`ifdef ALU_SHIFT_EN
      OP_SLL:           w_res = r_s1_a << w_shamt;
      OP_SRL:           w_res = r_s1_a >> w_shamt;
      OP_SRA:           w_res = $signed(r_s1_a) >>> w_shamt;
`endif
      default:          w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_s1_a  <= a;
      r_s1_b  <= b;
      r_s1_op <= op;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_z         <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid  <= in_valid;
      r_out_valid <= r_s1_valid;
      r_z         <= w_res;
      r_zero      <= (w_res == '0);
      r_ovf       <= w_ovf;
      r_illegal   <= w_illegal;
    end
  end

  // Setting takes priority over a simultaneous clear so no overflow event is ever lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf_sticky <= 1'b0;
      r_op_count   <= '0;
    end else begin
      if (w_out_fire && r_ovf)
        r_ovf_sticky <= 1'b1;
      else if (sticky_clr)
        r_ovf_sticky <= 1'b0;
      if (w_out_fire && (r_op_count != {CNT_W{1'b1}}))
        r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign out_valid  = r_out_valid;
  assign z          = r_z;
  assign zero       = r_zero;
  assign ovf        = r_ovf;
  assign illegal    = r_illegal;
  assign ovf_sticky = r_ovf_sticky;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_y_alu_pipe.sv
// Directed self-checking bench for y_alu_pipe (WIDTH=32); a second CNT_W=2 instance checks saturation.
// Shift expectations follow ALU_SHIFT_EN.
module tb_y_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] z;
  logic        zero;
  logic        ovf;
  logic        illegal;
  logic        ovf_sticky;
  logic        sticky_clr;
  logic [15:0] op_count;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_z;
  logic        s_zero;
  logic        s_ovf;
  logic        s_illegal;
  logic        s_ovf_sticky;
  logic [1:0]  s_op_count;

  int checks   = 0;
  int failures = 0;
  int expCount = 0;

  always #5 clk = ~clk;

  y_alu_pipe #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .zero(zero), .ovf(ovf), .illegal(illegal), .ovf_sticky(ovf_sticky),
    .sticky_clr(sticky_clr), .op_count(op_count)
  );

  y_alu_pipe #(.WIDTH(32), .CNT_W(2)) dutSmall (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .op(op), .out_valid(s_out_valid), .out_ready(out_ready),
    .z(s_z), .zero(s_zero), .ovf(s_ovf), .illegal(s_illegal), .ovf_sticky(s_ovf_sticky),
    .sticky_clr(sticky_clr), .op_count(s_op_count)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Offers one op for a single cycle; the result is on the output afterwards.
  task automatic sendOp(input logic [31:0] ta, input logic [31:0] tb, input logic [3:0] top);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    op = top;
    step;
    in_valid = 1'b0;
    step;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 32'd1;
    b = 32'd2;
    op = 4'b0010;
    out_ready = 1'b1;
    sticky_clr = 1'b0;
    step;
    step;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (op_count !== 16'd0) begin failures++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
    checks++;
    if (ovf_sticky !== 1'b0) begin failures++; $display("FAIL reset_sticky got=%b exp=0", ovf_sticky); end
    rst_n = 1'b1;
    in_valid = 1'b0;
    step;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL release_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] va[4];
    logic [31:0] vb[4];
    logic [3:0]  vop[4];
    logic [31:0] ez[4];
    logic        ezero[4];
    logic        eovf[4];
    va = '{32'h7FFFFFFF, 32'd5, 32'h80000000, 32'h80000000};
    vb = '{32'h00000001, 32'd5, 32'h00000001, 32'h00000001};
    vop = '{4'b0010, 4'b0110, 4'b0011, 4'b1011};
    ez = '{32'h80000000, 32'h0, 32'h1, 32'h0};
    ezero = '{1'b0, 1'b1, 1'b0, 1'b1};
    eovf = '{1'b1, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        in_valid = 1'b1;
        a = va[i];
        b = vb[i];
        op = vop[i];
      end else begin
        in_valid = 1'b0;
      end
      step;
      if (i >= 1 && i <= 4) begin
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i-1, out_valid); end
        checks++;
        if (z !== ez[i-1]) begin failures++; $display("FAIL b2b_z[%0d] got=%h exp=%h", i-1, z, ez[i-1]); end
        checks++;
        if (zero !== ezero[i-1]) begin failures++; $display("FAIL b2b_zero[%0d] got=%b exp=%b", i-1, zero, ezero[i-1]); end
        checks++;
        if (ovf !== eovf[i-1]) begin failures++; $display("FAIL b2b_ovf[%0d] got=%b exp=%b", i-1, ovf, eovf[i-1]); end
        checks++;
        if (illegal !== 1'b0) begin failures++; $display("FAIL b2b_illegal[%0d] got=%b exp=0", i-1, illegal); end
      end
      if (i >= 2) begin
        checks++;
        if (ovf_sticky !== 1'b1) begin failures++; $display("FAIL b2b_sticky[%0d] got=%b exp=1", i, ovf_sticky); end
      end
    end
    expCount += 4;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    checks++;
    if (op_count !== 16'(expCount)) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", op_count, expCount); end
  endtask

  task automatic test_sticky;
    sticky_clr = 1'b1;
    step;
    sticky_clr = 1'b0;
    checks++;
    if (ovf_sticky !== 1'b0) begin failures++; $display("FAIL sticky_preclear got=%b exp=0", ovf_sticky); end
    sendOp(32'h7FFFFFFF, 32'h00000001, 4'b0010);
    checks++;
    if (ovf !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL sticky_ovf_out got=%b/%b exp=1/1", ovf, out_valid); end
    sticky_clr = 1'b1;
    step;
    checks++;
    if (ovf_sticky !== 1'b1) begin failures++; $display("FAIL sticky_set_wins got=%b exp=1", ovf_sticky); end
    step;
    sticky_clr = 1'b0;
    checks++;
    if (ovf_sticky !== 1'b0) begin failures++; $display("FAIL sticky_clear got=%b exp=0", ovf_sticky); end
    expCount += 1;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 32'd1; b = 32'd2; op = 4'b0010;
    step;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_early_valid got=%b exp=0", out_valid); end
    a = 32'hF0F0F0F0; b = 32'h0FF00FF0; op = 4'b1000;
    step;
    a = 32'h00000011; b = 32'h00000100; op = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || z !== 32'd3) begin failures++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/00000003", i, out_valid, z); end
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
      if (i < 3) step;
    end
    out_ready = 1'b1;
    step;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || z !== 32'hFF00FF00) begin failures++; $display("FAIL bp_second got=%b/%h exp=1/ff00ff00", out_valid, z); end
    step;
    checks++;
    if (out_valid !== 1'b1 || z !== 32'h00000111) begin failures++; $display("FAIL bp_third got=%b/%h exp=1/00000111", out_valid, z); end
    step;
    expCount += 3;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    checks++;
    if (op_count !== 16'(expCount)) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", op_count, expCount); end
  endtask

  task automatic test_illegal;
    sendOp(32'h12345678, 32'h1, 4'b1111);
    checks++;
    if (z !== 32'h0 || zero !== 1'b1) begin failures++; $display("FAIL illegal_z got=%h/%b exp=00000000/1", z, zero); end
    checks++;
    if (illegal !== 1'b1 || ovf !== 1'b0) begin failures++; $display("FAIL illegal_flag got=%b/%b exp=1/0", illegal, ovf); end
    step;
    expCount += 1;
    checks++;
    if (op_count !== 16'(expCount)) begin failures++; $display("FAIL illegal_count got=%0d exp=%0d", op_count, expCount); end
    sendOp(32'h80000000, 32'd4, 4'b1110);
`ifdef ALU_SHIFT_EN
    checks++;
    if (z !== 32'hF8000000 || illegal !== 1'b0) begin failures++; $display("FAIL sra got=%h/%b exp=f8000000/0", z, illegal); end
`else
    checks++;
    if (z !== 32'h0 || illegal !== 1'b1 || zero !== 1'b1) begin failures++; $display("FAIL sra_off got=%h/%b/%b exp=00000000/1/1", z, illegal, zero); end
`endif
    step;
    expCount += 1;
    checks++;
    if (op_count !== 16'(expCount)) begin failures++; $display("FAIL shift_count got=%0d exp=%0d", op_count, expCount); end
  endtask

  task automatic test_reset_inflight;
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 32'd10; b = 32'd20; op = 4'b0010;
    step;
    a = 32'd30; b = 32'd40; op = 4'b0010;
    step;
    in_valid = 1'b0;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL inflight_valid[%0d] got=%b exp=0", i, out_valid); end
    end
    expCount = 0;
    checks++;
    if (op_count !== 16'd0 || s_op_count !== 2'd0) begin failures++; $display("FAIL inflight_count got=%0d/%0d exp=0/0", op_count, s_op_count); end
  endtask

  task automatic test_saturate;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin
        in_valid = 1'b1;
        a = 32'(i);
        b = 32'd1;
        op = 4'b0010;
      end else begin
        in_valid = 1'b0;
      end
      step;
    end
    checks++;
    if (op_count !== 16'd5) begin failures++; $display("FAIL sat_main_count got=%0d exp=5", op_count); end
    checks++;
    if (s_op_count !== 2'd3) begin failures++; $display("FAIL sat_small_count got=%0d exp=3", s_op_count); end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_sticky;
    test_backpressure;
    test_illegal;
    test_reset_inflight;
    test_saturate;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
